ascii_num_formatter: RTL and testbench
======================================

Name: ascii_num_formatter

Overview:
- Transmit-side counterpart of the ASCII number validator/separator path.
- Accepts a stream of signed integers and serialises them as ASCII decimal text: digits, '-' and ' ' (0x20).
- Drives the payload byte interface of the UART packet builder, with the same payload_data/valid/last/ready handshake the receive side uses.
- Text it emits always passes the receive-side validator.

Parameters:
- DATA_WIDTH, 32, width of signed input numbers (legal 4..32).
- MAX_DIGITS, derived localparam, ceil(DATA_WIDTH*log10(2)); equals 10 for 32.
- COLS, 4, numbers per line; used only when ASCII_FMT_ROWS_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- num_data  in  DATA_WIDTH  signed two's-complement number.
- num_valid  in  1  num_data valid.
- num_last  in  1  this number is the final one of the packet.
- num_ready  out  1  block can accept a number.
- payload_data  out  8  ASCII byte.
- payload_valid  out  1  payload_data valid.
- payload_last  out  1  final byte of the packet.
- payload_ready  in  1  downstream accepts the byte.
- byte_count  out  16  bytes emitted in the current/last packet.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values: num_ready=0 during reset, 1 in IDLE after; payload_valid=0, payload_last=0, payload_data=0, byte_count=0, done=0; FSM=IDLE.
- Reset asserted mid-operation abandons the current number and packet in the same cycle; no partial byte is completed.
- FSM states: IDLE, CONVERT, EMIT_SIGN, EMIT_DIGIT, EMIT_SEP.
- IDLE:
  - num_ready=1.
  - On num_valid, latch sign, magnitude and last flag, then go to CONVERT.
  - If byte_count was from a finished packet, clear it on this acceptance.
- Magnitude is computed unsigned at DATA_WIDTH bits, so -2^(DATA_WIDTH-1) is exact (0x80000000 gives 2147483648).
- CONVERT:
  - One digit per cycle: magnitude%10 pushed onto a MAX_DIGITS digit stack, magnitude/10 kept.
  - Ends when the quotient reaches 0; always at least one digit, so zero yields "0".
  - Takes ndigits cycles.
  - Next state is EMIT_SIGN if negative, else EMIT_DIGIT.
- EMIT states: byte = '-' (0x2D), '0'+digit (LSB of stack popped last; most-significant digit first), or separator 0x20.
- Output handshake:
  - payload_valid rises the cycle after CONVERT completes.
  - payload_data/payload_last are held stable while valid && !ready.
  - Advance only on valid && ready.
  - byte_count increments on each accepted byte; saturates at 0xFFFF.
- After the final digit:
  - If the number is not last: EMIT_SEP, then IDLE.
  - If last: payload_last=1 on that final digit; after acceptance, pulse done and go to IDLE. No trailing separator.
- Leading zeros are never emitted.
- num_ready is low in every state except IDLE; there is no input buffering.
- Throughput for an n-digit positive non-last number with ready held high: 1 (accept) + n (convert) + n + 1 (emit) cycles.

Optional Feature:
- Macro ASCII_FMT_ROWS_EN.
- Defined:
  - A column counter (0..COLS-1) counts numbers within the packet.
  - The separator after every COLS-th number is 0x0A instead of 0x20.
  - The counter clears at packet end and on reset.
  - The last number still has no trailing separator.
- Undefined: separator is always 0x20; COLS is ignored and no counter logic is generated.

Decomposition:
- Shared package ascii_num_pkg holds:
  - ASCII constants CH_ZERO=0x30, CH_MINUS=0x2D, CH_SPACE=0x20, CH_LF=0x0A.
  - The FSM state enum.
  - A function computing MAX_DIGITS from DATA_WIDTH.
- The receive-side validator imports the same constants.
- One natural sub-module, ascii_digit_stack: a MAX_DIGITS x 4-bit LIFO with push/pop/empty, reset to empty.

Test Plan:
- 123 with last=1, ready always 1 -> bytes 0x31,0x32,0x33; payload_last only on 0x33; byte_count=3; done pulses once.
- Sequence -5, 0, 42 (last on 42) -> "-5 0 42" (7 bytes); payload_last on '2'; no byte after it.
- -2147483648 (DATA_WIDTH=32, last) -> "-2147483648", 11 bytes; 2147483647 -> "2147483647", 10 bytes.
- Input 907 with payload_ready toggling 1/0 every cycle -> payload_data never changes while valid && !ready; output "907"; num_ready stays 0 until the final byte is accepted.
- Reset asserted during the second digit of 4567 -> next cycle payload_valid=0, byte_count=0; a fresh 8 afterwards emits "8" only.
- With ASCII_FMT_ROWS_EN and COLS=2, input 1, 2, 3, 4 (last) -> "1 2\n3 4": 0x31,0x20,0x32,0x0A,0x33,0x20,0x34.

Source files
------------

// File: rtl/ascii_num_pkg.sv
// Shared ASCII constants, formatter FSM encoding and sizing helper
// for the ASCII number transmit/receive path.
package ascii_num_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef logic [3:0] digit_t;
  typedef logic [2:0] fmt_state_t;

  localparam fmt_state_t ST_IDLE       = 3'd0;
  localparam fmt_state_t ST_CONVERT    = 3'd1;
  localparam fmt_state_t ST_EMIT_SIGN  = 3'd2;
  localparam fmt_state_t ST_EMIT_DIGIT = 3'd3;
  localparam fmt_state_t ST_EMIT_SEP   = 3'd4;

  // Decimal digits of 2^width-1, i.e. ceil(width*log10(2)).
  function automatic int max_digits(input int width);
    logic [63:0] v;
    int          n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ascii_num_formatter_digit_stack.sv
// ascii_digit_stack: DEPTH x 4-bit LIFO holding decimal digits,
// least-significant pushed first so pops come out MSD first.
module ascii_digit_stack
  import ascii_num_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  digit_t push_digit,
  output digit_t top_digit,
  output logic   empty,
  output logic   single
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  digit_t         mem [DEPTH];
  logic [PW-1:0]  cnt;
  logic [PW-1:0]  top_idx;

  assign top_idx   = cnt - PW'(1);
  assign empty     = (cnt == '0);
  assign single    = (cnt == PW'(1));
  assign top_digit = empty ? 4'd0 : mem[top_idx[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cnt + PW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[cnt[IW-1:0]] <= push_digit;
    end
  end

endmodule

// File: rtl/ascii_num_formatter.sv
// Signed integer stream to ASCII decimal text serialiser.
// Optional ASCII_FMT_ROWS_EN: LF separator after every COLS-th number.
module ascii_num_formatter
  import ascii_num_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COLS       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] num_data,
  input  logic                  num_valid,
  input  logic                  num_last,
  output logic                  num_ready,
  output logic [7:0]            payload_data,
  output logic                  payload_valid,
  output logic                  payload_last,
  input  logic                  payload_ready,
  output logic [15:0]           byte_count,
  output logic                  done
);

  localparam int MAX_DIGITS = max_digits(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] TEN = DATA_WIDTH'(10);

  if (DATA_WIDTH < 4 || DATA_WIDTH > 32 || COLS < 1) begin : g_bad_cfg
    $error("ascii_num_formatter: illegal DATA_WIDTH or COLS");
  end

  fmt_state_t            state;
  logic                  neg_q;
  logic                  last_q;
  logic                  pkt_end;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] quot;
  logic [15:0]           byte_count_q;
  logic                  done_q;
  digit_t                new_digit;
  digit_t                top_digit;
  logic                  stk_empty;
  logic                  one_left;
  logic                  accept_byte;
  logic [7:0]            sep_char;

  assign quot      = mag / TEN;
  assign new_digit = 4'(mag % TEN);

  assign num_ready     = !rst && (state == ST_IDLE);
  assign payload_valid = (state == ST_EMIT_SIGN)
                      || (state == ST_EMIT_SEP)
                      || (state == ST_EMIT_DIGIT && !stk_empty);
  assign accept_byte   = payload_valid && payload_ready;
  assign payload_last  = (state == ST_EMIT_DIGIT) && one_left && last_q;
  assign byte_count    = byte_count_q;
  assign done          = done_q;

  ascii_digit_stack #(
    .DEPTH(MAX_DIGITS)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (state == ST_CONVERT),
    .pop       (accept_byte && state == ST_EMIT_DIGIT),
    .push_digit(new_digit),
    .top_digit (top_digit),
    .empty     (stk_empty),
    .single    (one_left)
  );

  always_comb begin
    payload_data = 8'h00;
    unique case (state)
      ST_EMIT_SIGN:  payload_data = CH_MINUS;
      ST_EMIT_DIGIT: payload_data = CH_ZERO + {4'd0, top_digit};
      ST_EMIT_SEP:   payload_data = sep_char;
      default:       payload_data = 8'h00;
    endcase
  end

`ifdef ASCII_FMT_ROWS_EN
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  logic [CW-1:0] col;

  assign sep_char = (col == CW'(COLS - 1)) ? CH_LF : CH_SPACE;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
    end else if (accept_byte && state == ST_EMIT_SEP) begin
      col <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
    end else if (accept_byte && payload_last) begin
      col <= '0;
    end
  end
`else
  assign sep_char = CH_SPACE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      neg_q        <= 1'b0;
      last_q       <= 1'b0;
      pkt_end      <= 1'b0;
      mag          <= '0;
      byte_count_q <= 16'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_byte && byte_count_q != 16'hFFFF) begin
        byte_count_q <= byte_count_q + 16'd1;
      end
      unique case (state)
        ST_IDLE: begin
          if (num_valid) begin
            neg_q  <= num_data[DATA_WIDTH-1];
            mag    <= num_data[DATA_WIDTH-1]
                    ? (~num_data + DATA_WIDTH'(1))
                    : num_data;
            last_q <= num_last;
            state  <= ST_CONVERT;
            if (pkt_end) begin
              byte_count_q <= 16'd0;
              pkt_end      <= 1'b0;
            end
          end
        end
        ST_CONVERT: begin
          mag <= quot;
          if (quot == '0) begin
            state <= neg_q ? ST_EMIT_SIGN : ST_EMIT_DIGIT;
          end
        end
        ST_EMIT_SIGN: begin
          if (payload_ready) state <= ST_EMIT_DIGIT;
        end
        ST_EMIT_DIGIT: begin
          if (accept_byte && one_left) begin
            if (last_q) begin
              state   <= ST_IDLE;
              done_q  <= 1'b1;
              pkt_end <= 1'b1;
            end else begin
              state <= ST_EMIT_SEP;
            end
          end
        end
        ST_EMIT_SEP: begin
          if (payload_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_num_formatter.sv
// Self-checking bench for ascii_num_formatter; reference text is built
// with $sformatf("%0d") per number plus separators.
module tb_ascii_num_formatter;

  localparam int DW = 32;
`ifdef ASCII_FMT_ROWS_EN
  localparam int COLS = 2;
`else
  localparam int COLS = 4;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] num_data;
  logic          num_valid;
  logic          num_last;
  logic          num_ready;
  logic [7:0]    payload_data;
  logic          payload_valid;
  logic          payload_last;
  logic          payload_ready;
  logic [15:0]   byte_count;
  logic          done;

  int checks   = 0;
  int failures = 0;

  ascii_num_formatter #(
    .DATA_WIDTH(DW),
    .COLS      (COLS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .num_data     (num_data),
    .num_valid    (num_valid),
    .num_last     (num_last),
    .num_ready    (num_ready),
    .payload_data (payload_data),
    .payload_valid(payload_valid),
    .payload_last (payload_last),
    .payload_ready(payload_ready),
    .byte_count   (byte_count),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void build_expected(input int nums[$],
                                         output logic [7:0] q[$]);
    string s;
    q = {};
    for (int i = 0; i < nums.size(); i++) begin
      s = $sformatf("%0d", nums[i]);
      for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
      if (i != nums.size() - 1) begin
`ifdef ASCII_FMT_ROWS_EN
        if ((i + 1) % COLS == 0) q.push_back(8'h0A);
        else q.push_back(8'h20);
`else
        q.push_back(8'h20);
`endif
      end
    end
  endfunction

  function automatic string hexq(input logic [7:0] q[$]);
    string r;
    r = "";
    for (int i = 0; i < q.size(); i++) r = $sformatf("%s%02h ", r, q[i]);
    return r;
  endfunction

  task automatic run_packet(input string name, input int nums[$],
                            input int mode);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    int   idx, cyc, done_cnt, last_cnt, last_pos;
    int   stab_err, overlap, extra;
    bit   prev_v, prev_r, prev_l, finished, mism;
    logic [7:0] prev_d;
    build_expected(nums, exp);
    got = {};
    idx = 0; cyc = 0; done_cnt = 0; last_cnt = 0; last_pos = -1;
    stab_err = 0; overlap = 0; extra = 0;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 8'h00;
    finished = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      num_valid = (idx < nums.size());
      num_data  = (idx < nums.size()) ? nums[idx] : 0;
      num_last  = (idx == nums.size() - 1);
      case (mode)
        0:       payload_ready = 1'b1;
        1:       payload_ready = cyc[0];
        default: payload_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_v && !prev_r &&
          (!payload_valid || payload_data !== prev_d ||
           payload_last !== prev_l)) stab_err++;
      if (payload_valid && num_ready) overlap++;
      if (payload_valid && payload_ready) begin
        got.push_back(payload_data);
        if (payload_last) begin
          last_cnt++;
          last_pos = got.size() - 1;
        end
      end
      if (num_valid && num_ready) idx++;
      prev_v = payload_valid;
      prev_r = payload_ready;
      prev_d = payload_data;
      prev_l = payload_last;
      if (done_cnt > 0) finished = 1;
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s timeout: done not seen after %0d cycles, required 1",
               name, cyc);
    end
    num_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      payload_ready = 1'b1;
      #1;
      if (payload_valid) extra++;
      if (done) done_cnt++;
    end
    mism = (got.size() != exp.size());
    for (int i = 0; i < got.size() && !mism; i++)
      if (got[i] !== exp[i]) mism = 1;
    checks++;
    if (mism) begin
      failures++;
      $display("FAIL %s bytes: got %s required %s", name, hexq(got),
               hexq(exp));
    end
    checks++;
    if (byte_count !== 16'(exp.size())) begin
      failures++;
      $display("FAIL %s byte_count: got %0d required %0d", name,
               byte_count, exp.size());
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL %s done pulses: got %0d required 1", name, done_cnt);
    end
    checks++;
    if (last_cnt !== 1 || last_pos !== exp.size() - 1) begin
      failures++;
      $display("FAIL %s payload_last: count %0d at %0d required 1 at %0d",
               name, last_cnt, last_pos, exp.size() - 1);
    end
    checks++;
    if (stab_err !== 0) begin
      failures++;
      $display("FAIL %s hold stability: %0d changes required 0", name,
               stab_err);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL %s num_ready while emitting: %0d required 0", name,
               overlap);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL %s bytes after last: %0d required 0", name, extra);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    num_valid = 1'b0; num_data = '0; num_last = 1'b0;
    payload_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (num_ready !== 1'b0 || payload_valid !== 1'b0 ||
        payload_last !== 1'b0 || payload_data !== 8'h00 ||
        byte_count !== 16'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b v=%b l=%b d=%02h bc=%0d dn=%b required 0 0 0 00 0 0",
               num_ready, payload_valid, payload_last, payload_data,
               byte_count, done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (num_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready: got %b required 1", num_ready);
    end
  endtask

  task automatic test_basic();
    int q[$];
    q = {123};
    run_packet("basic_123", q, 0);
    q = {-5, 0, 42};
    run_packet("seq_m5_0_42", q, 0);
  endtask

  task automatic test_extremes();
    int q[$];
    q = {int'(32'h80000000)};
    run_packet("min_int", q, 0);
    q = {2147483647};
    run_packet("max_int", q, 2);
  endtask

  task automatic test_backpressure();
    int q[$];
    q = {907};
    run_packet("bp_907", q, 1);
  endtask

  task automatic test_rows();
    int q[$];
    q = {1, 2, 3, 4};
    run_packet("rows_1234", q, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    payload_ready = 1'b1;
    num_valid = 1'b1; num_data = 4567; num_last = 1'b1;
    @(negedge clk);
    num_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (payload_valid && payload_data == 8'h35) seen = 1;
    end
    checks++;
    if (!seen || byte_count !== 16'd1) begin
      failures++;
      $display("FAIL mid_second_digit: seen=%b bc=%0d required 1 1",
               seen, byte_count);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (payload_valid !== 1'b0 || byte_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b bc=%0d required 0 0",
               payload_valid, byte_count);
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      int q[$];
      q = {8};
      run_packet("after_reset_8", q, 0);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int n, r;
    for (int p = 0; p < 6; p++) begin
      q = {};
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       q.push_back(int'($urandom_range(0, 9)));
          1:       q.push_back(-int'($urandom_range(0, 999)));
          2:       q.push_back(int'($urandom()));
          default: begin
            case ($urandom_range(0, 3))
              0:       q.push_back(0);
              1:       q.push_back(-1);
              2:       q.push_back(2147483647);
              default: q.push_back(int'(32'h80000000));
            endcase
          end
        endcase
      end
      run_packet($sformatf("rand_pkt%0d", p), q, p % 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_rows();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
